// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the CPU run/halt sequencer.
package clock_ctrl_pkg;

  localparam int unsigned DEFAULT_COUNT_WIDTH = 32;

  typedef enum logic [2:0] {
    StStartup = 3'd0,
    StIdle    = 3'd1,
    StRun     = 3'd2,
    StBurst   = 3'd3,
    StHalted  = 3'd4
  } state_e;

  localparam logic [2:0] STATE_STARTUP = 3'd0;
  localparam logic [2:0] STATE_IDLE    = 3'd1;
  localparam logic [2:0] STATE_RUN     = 3'd2;
  localparam logic [2:0] STATE_BURST   = 3'd3;
  localparam logic [2:0] STATE_HALTED  = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; cleared only by reset.
module sat_counter
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             INC,
  output logic [WIDTH-1:0] COUNT
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      count_q <= '0;
    end else if (INC && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign COUNT = count_q;

endmodule

// File: rtl/clock_run_controller.sv
// Run/halt sequencer producing a registered CPU clock-enable with start, stop,
// single-step and fixed-length burst control plus a saturating enabled-cycle count.
module clock_run_controller
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = DEFAULT_COUNT_WIDTH,
  parameter int unsigned STARTUP_CYCLES = 4
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic                   START,
  input  logic                   STOP,
  input  logic                   STEP,
  input  logic                   BURST,
  input  logic [COUNT_WIDTH-1:0] RUN_LEN,
  input  logic                   HALT,
  output logic                   CLK_EN,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [2:0]             STATE,
  output logic [COUNT_WIDTH-1:0] CYCLE_COUNT
);

  localparam int unsigned SW = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;

  state_e                 state_q;
  logic                   clk_en_q;
  logic                   done_q;
  logic [COUNT_WIDTH-1:0] burst_cnt_q;
  logic [SW-1:0]          start_cnt_q;

  // clk_en_q is set on exactly the edges that leave the FSM in RUN or BURST, so it
  // tracks those states while staying a plain flop output.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q     <= (STARTUP_CYCLES == 0) ? StIdle : StStartup;
      clk_en_q    <= 1'b0;
      done_q      <= 1'b0;
      burst_cnt_q <= '0;
      start_cnt_q <= SW'(STARTUP_CYCLES);
    end else begin
      clk_en_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        StStartup: begin
          if (start_cnt_q <= SW'(1)) begin
            start_cnt_q <= '0;
            state_q     <= StIdle;
          end else begin
            start_cnt_q <= start_cnt_q - 1'b1;
          end
        end
        StIdle: begin
          if (STOP) begin
            state_q <= StIdle;
          end else if (START) begin
            state_q  <= StRun;
            clk_en_q <= 1'b1;
          end else if (BURST) begin
            if (RUN_LEN != '0) begin
              state_q     <= StBurst;
              burst_cnt_q <= RUN_LEN;
              clk_en_q    <= 1'b1;
            end else begin
              // Empty burst completes at once; never emit DONE on back-to-back cycles.
              done_q <= ~done_q;
            end
          end else if (STEP) begin
            state_q     <= StBurst;
            burst_cnt_q <= COUNT_WIDTH'(1);
            clk_en_q    <= 1'b1;
          end
        end
        StRun: begin
          if (STOP) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else if (HALT) begin
            state_q <= StHalted;
            done_q  <= 1'b1;
          end else begin
            clk_en_q <= 1'b1;
          end
        end
        StBurst: begin
          if (STOP) begin
            state_q     <= StIdle;
            done_q      <= 1'b1;
            burst_cnt_q <= '0;
          end else if (HALT) begin
            state_q     <= StHalted;
            done_q      <= 1'b1;
            burst_cnt_q <= '0;
          end else if (burst_cnt_q <= COUNT_WIDTH'(1)) begin
            state_q     <= StIdle;
            done_q      <= 1'b1;
            burst_cnt_q <= '0;
          end else begin
            burst_cnt_q <= burst_cnt_q - 1'b1;
            clk_en_q    <= 1'b1;
          end
        end
        StHalted: begin
          if (STOP) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_cycle_count (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .INC     (clk_en_q),
    .COUNT   (CYCLE_COUNT)
  );

  assign CLK_EN = clk_en_q;
  assign DONE   = done_q;
  assign STATE  = state_q;
  assign BUSY   = (state_q == StStartup) || (state_q == StRun) || (state_q == StBurst);

endmodule
